vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640x480@60 Hz sync logic.
- Generates horizontal/vertical counters, sync pulses with configurable polarity, and visible-area flag.
- Adds line/frame strobes, a frame counter, a pixel clock-enable and a PIPE_DELAY-stage sync/visible delay line, so syncs line up with pixel generators that have registered pipelines.
- Sits between the clock/reset domain and the pixel generator / VGA pin drivers.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync pulses, visible flag,
// line/frame strobes, frame counter and a pix_ce-qualified delay line for the sync/visible outputs.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIPE_DELAY  = 0,
  parameter int FRAME_CNT_W = 8,
  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_ce,
  output logic [HW-1:0]          h_count,
  output logic [VW-1:0]          v_count,
  output logic                   visible,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   hsync_d,
  output logic                   vsync_d,
  output logic                   visible_d
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [31:0]   HS_START = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0]   HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0]   VS_START = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0]   VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_SYNC <= 0) begin : g_bad_hsync
    $error("vga_timing_gen: H_SYNC must be positive");
  end
  if (V_SYNC <= 0) begin : g_bad_vsync
    $error("vga_timing_gen: V_SYNC must be positive");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be within 0..15");
  end

  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [FRAME_CNT_W-1:0] f_q, f_d;
  logic [31:0]            h_ext, v_ext;
  logic                   hs_act, vs_act;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    f_d = f_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
          f_d = f_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      f_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      f_q <= f_d;
    end
  end

  // Decode straight from the counter registers so syncs have zero latency to h/v_count.
  assign h_ext       = 32'(h_q);
  assign v_ext       = 32'(v_q);
  assign hs_act      = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_act      = (v_ext >= VS_START) && (v_ext < VS_END);
  assign hsync       = hs_act ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = vs_act ? VSYNC_POL : ~VSYNC_POL;
  assign visible     = (h_ext < 32'(H_VISIBLE)) && (v_ext < 32'(V_VISIBLE));
  assign line_start  = pix_ce && (h_q == '0);
  assign frame_start = pix_ce && (h_q == '0) && (v_q == '0);
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign frame_count = f_q;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync_d   = hsync;
    assign vsync_d   = vsync;
    assign visible_d = visible;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_q, vs_q, vis_q;

    // Reset loads inactive levels so no stale sync pulse drains out after a mid-frame reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        hs_q  <= {PIPE_DELAY{~HSYNC_POL}};
        vs_q  <= {PIPE_DELAY{~VSYNC_POL}};
        vis_q <= '0;
      end else if (pix_ce) begin
        hs_q[0]  <= hsync;
        vs_q[0]  <= vsync;
        vis_q[0] <= visible;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
          vis_q[i] <= vis_q[i-1];
        end
      end
    end

    assign hsync_d   = hs_q[PIPE_DELAY-1];
    assign vsync_d   = vs_q[PIPE_DELAY-1];
    assign visible_d = vis_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny raster with
// active-high syncs and 2-bit frame counter, and a PIPE_DELAY=3 instance under pix_ce gating.
module tb_vga_timing_gen;

  logic clk;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       d_rst, d_ce;
  logic [9:0] d_h, d_v;
  logic       d_vis, d_hs, d_vs, d_ls, d_fs, d_hsd, d_vsd, d_visd;
  logic [7:0] d_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .pix_ce(d_ce),
    .h_count(d_h), .v_count(d_v), .visible(d_vis), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc),
    .hsync_d(d_hsd), .vsync_d(d_vsd), .visible_d(d_visd)
  );

  // Tiny raster: H 4/1/1/1 (total 7), V 3/1/1/1 (total 6), active-high syncs
  logic       s_rst, s_ce;
  logic [2:0] s_h, s_v;
  logic       s_vis, s_hs, s_vs, s_ls, s_fs, s_hsd, s_vsd, s_visd;
  logic [1:0] s_fc;

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FRAME_CNT_W(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .pix_ce(s_ce),
    .h_count(s_h), .v_count(s_v), .visible(s_vis), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc),
    .hsync_d(s_hsd), .vsync_d(s_vsd), .visible_d(s_visd)
  );

  // Default timing with a 3-stage delay line
  logic       p_rst, p_ce;
  logic [9:0] p_h, p_v;
  logic       p_vis, p_hs, p_vs, p_ls, p_fs, p_hsd, p_vsd, p_visd;
  logic [7:0] p_fc;

  vga_timing_gen #(.PIPE_DELAY(3)) u_pipe (
    .clk(clk), .rst(p_rst), .pix_ce(p_ce),
    .h_count(p_h), .v_count(p_v), .visible(p_vis), .hsync(p_hs), .vsync(p_vs),
    .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc),
    .hsync_d(p_hsd), .vsync_d(p_vsd), .visible_d(p_visd)
  );

  // Scoreboard for the delay line: entries are {hsync, visible} per pix_ce stage
  logic [1:0] exp_q[$];
  int         mh, mv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic def_hs(input int h);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic logic def_vis(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  task automatic pipe_reset_model();
    exp_q.delete();
    repeat (3) exp_q.push_back(2'b10);
    mh = 0;
    mv = 0;
  endtask

  // One clock on the delayed instance: check against the model, then advance it if ce.
  task automatic pipe_cycle(input logic ce);
    logic [1:0] head;
    p_ce = ce;
    #1;
    head = exp_q[0];
    check_eq("pipe.h_count", 32'(p_h), 32'(mh));
    check_eq("pipe.v_count", 32'(p_v), 32'(mv));
    check_eq("pipe.hsync", 32'(p_hs), 32'(def_hs(mh)));
    check_eq("pipe.hsync_d", 32'(p_hsd), 32'(head[1]));
    check_eq("pipe.visible_d", 32'(p_visd), 32'(head[0]));
    check_eq("pipe.vsync_d", 32'(p_vsd), 32'(1'b1));
    check_eq("pipe.line_start", 32'(p_ls), 32'(ce && mh == 0));
    check_eq("pipe.frame_start", 32'(p_fs), 32'(ce && mh == 0 && mv == 0));
    if (ce) begin
      exp_q.push_back({def_hs(mh), def_vis(mh, mv)});
      void'(exp_q.pop_front());
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    d_rst = 1'b1; d_ce = 1'b1;
    s_rst = 1'b1; s_ce = 1'b1;
    p_rst = 1'b1; p_ce = 1'b1;
    repeat (3) step();

    // Reset state, default instance
    check_eq("def.rst.h_count", 32'(d_h), 32'd0);
    check_eq("def.rst.v_count", 32'(d_v), 32'd0);
    check_eq("def.rst.frame_count", 32'(d_fc), 32'd0);
    check_eq("def.rst.hsync", 32'(d_hs), 32'd1);
    check_eq("def.rst.vsync", 32'(d_vs), 32'd1);
    check_eq("def.rst.visible", 32'(d_vis), 32'd1);
    check_eq("def.rst.hsync_d", 32'(d_hsd), 32'd1);
    check_eq("def.rst.vsync_d", 32'(d_vsd), 32'd1);
    check_eq("pipe.rst.visible_d", 32'(p_visd), 32'd0);
    check_eq("pipe.rst.hsync_d", 32'(p_hsd), 32'd1);

    d_rst = 1'b0;
    #1;
    check_eq("def.first.frame_start", 32'(d_fs), 32'd1);
    check_eq("def.first.line_start", 32'(d_ls), 32'd1);

    // One full line of default timing
    for (int i = 0; i < 800; i++) begin
      check_eq("def.line.h_count", 32'(d_h), 32'(i));
      check_eq("def.line.v_count", 32'(d_v), 32'd0);
      check_eq("def.line.hsync", 32'(d_hs), 32'(!(i >= 656 && i <= 751)));
      check_eq("def.line.vsync", 32'(d_vs), 32'd1);
      check_eq("def.line.visible", 32'(d_vis), 32'(i < 640));
      check_eq("def.line.line_start", 32'(d_ls), 32'(i == 0));
      check_eq("def.line.frame_start", 32'(d_fs), 32'(i == 0));
      step();
    end
    check_eq("def.wrap.h_count", 32'(d_h), 32'd0);
    check_eq("def.wrap.v_count", 32'(d_v), 32'd1);
    check_eq("def.wrap.line_start", 32'(d_ls), 32'd1);
    check_eq("def.wrap.frame_start", 32'(d_fs), 32'd0);
    check_eq("def.wrap.visible", 32'(d_vis), 32'd1);

    // Strobes gated by pix_ce and counters hold
    d_ce = 1'b0;
    #1;
    check_eq("def.noce.line_start", 32'(d_ls), 32'd0);
    step();
    check_eq("def.noce.h_count", 32'(d_h), 32'd0);
    check_eq("def.noce.v_count", 32'(d_v), 32'd1);
    check_eq("def.noce.line_start", 32'(d_ls), 32'd0);
    d_ce = 1'b1;

    // Tiny raster: six full frames plus the start of the seventh
    s_rst = 1'b0;
    #1;
    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < 6; v++) begin
        for (int h = 0; h < 7; h++) begin
          check_eq("small.h_count", 32'(s_h), 32'(h));
          check_eq("small.v_count", 32'(s_v), 32'(v));
          check_eq("small.hsync", 32'(s_hs), 32'(h == 5));
          check_eq("small.vsync", 32'(s_vs), 32'(v == 4));
          check_eq("small.visible", 32'(s_vis), 32'(h < 4 && v < 3));
          check_eq("small.frame_count", 32'(s_fc), 32'(f % 4));
          check_eq("small.frame_start", 32'(s_fs), 32'(h == 0 && v == 0));
          check_eq("small.line_start", 32'(s_ls), 32'(h == 0));
          step();
        end
      end
    end
    check_eq("small.f6.frame_count", 32'(s_fc), 32'd2);
    check_eq("small.f6.h_count", 32'(s_h), 32'd0);
    check_eq("small.f6.v_count", 32'(s_v), 32'd0);
    check_eq("small.f6.frame_start", 32'(s_fs), 32'd1);
    repeat (10) step();
    check_eq("small.mid.h_count", 32'(s_h), 32'd3);
    check_eq("small.mid.v_count", 32'(s_v), 32'd1);
    s_rst = 1'b1;
    step();
    check_eq("small.rst.h_count", 32'(s_h), 32'd0);
    check_eq("small.rst.v_count", 32'(s_v), 32'd0);
    check_eq("small.rst.frame_count", 32'(s_fc), 32'd0);
    s_rst = 1'b0;

    // Delayed instance with pix_ce alternating 1,0,1,0
    p_rst = 1'b0;
    pipe_reset_model();
    for (int i = 0; i < 2000; i++) pipe_cycle(i % 2 == 0);
    while (mh != 700) pipe_cycle(1'b1);

    // Reset mid-line while a sync pulse is inside the delay line
    check_eq("pipe.pre.hsync_d", 32'(p_hsd), 32'd0);
    p_rst = 1'b1;
    p_ce = 1'b1;
    step();
    check_eq("pipe.rst.h_count", 32'(p_h), 32'd0);
    check_eq("pipe.rst.v_count", 32'(p_v), 32'd0);
    check_eq("pipe.rst.frame_count", 32'(p_fc), 32'd0);
    check_eq("pipe.rst.hsync_d", 32'(p_hsd), 32'd1);
    check_eq("pipe.rst.visible_d", 32'(p_visd), 32'd0);
    p_rst = 1'b0;
    pipe_reset_model();
    for (int i = 0; i < 12; i++) pipe_cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
